// File: rtl/rf_ram_ctrl.sv
// rf_ram_ctrl: software access port onto an ECC-protected register-file RAM.
// Hardware writes always own the RAM write port; a software write that
// collides with one is parked and issued in the first free cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accept one software request (read, write or invalid)
// WR_HOLD | software write parked behind hardware writes
// RD_WAIT | read issued, waiting out the RAM read pipeline
module rf_ram_ctrl #(
   parameter int DATASIZE  = 78,
   parameter int ADDRSIZE  = 9,
   parameter int PIPELINED = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic [ADDRSIZE-1:0] sw_address,
   input  logic                sw_read_en,
   input  logic                sw_write_en,
   input  logic [DATASIZE-1:0] sw_write_data,
   output logic [DATASIZE-1:0] sw_read_data,
   output logic                sw_access_complete,
   output logic                sw_invalid,
   input  logic                hw_wen,
   input  logic [ADDRSIZE-1:0] hw_waddr,
   input  logic [DATASIZE-1:0] hw_wdata,
   output logic                ram_wen,
   output logic [ADDRSIZE-1:0] ram_waddr,
   output logic [DATASIZE-1:0] ram_wdata,
   output logic                ram_ren,
   output logic [ADDRSIZE-1:0] ram_raddr,
   input  logic [DATASIZE-1:0] ram_rdata,
   input  logic                ram_sec,
   input  logic                ram_ded,
   output logic [CNT_WIDTH-1:0] sec_cnt,
   output logic [CNT_WIDTH-1:0] ded_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_HOLD = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   // RD_WAIT lasts WAIT_LOAD+1 cycles; the counter reaching zero marks capture.
   localparam logic                 WAIT_LOAD = (PIPELINED != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   state_t              state, state_nxt;
   logic [ADDRSIZE-1:0] hold_addr;
   logic [DATASIZE-1:0] hold_data;
   logic [ADDRSIZE-1:0] rd_addr;
   logic                wait_cnt;

   logic req_rd, req_wr, req_bad;
   logic wr_now, wr_defer, hold_issue, rd_capture;

   // Request decode: software inputs only matter in IDLE.
   always_comb begin
      req_rd     = (state == IDLE) && sw_read_en && !sw_write_en;
      req_wr     = (state == IDLE) && sw_write_en && !sw_read_en;
      req_bad    = (state == IDLE) && sw_write_en && sw_read_en;
      wr_now     = req_wr && !hw_wen;
      wr_defer   = req_wr && hw_wen;
      hold_issue = (state == WR_HOLD) && !hw_wen;
      rd_capture = (state == RD_WAIT) && (wait_cnt == 1'b0);
   end

   // State register.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_rd)        state_nxt = RD_WAIT;
            else if (wr_defer) state_nxt = WR_HOLD;
         end
         WR_HOLD: if (hold_issue) state_nxt = IDLE;
         RD_WAIT: if (rd_capture) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port drive; hardware writes pass through even while in reset.
   always_comb begin
      ram_wen   = hw_wen || (res_n && (wr_now || hold_issue));
      ram_waddr = sw_address;
      ram_wdata = sw_write_data;
      if (hw_wen) begin
         ram_waddr = hw_waddr;
         ram_wdata = hw_wdata;
      end else if (hold_issue) begin
         ram_waddr = hold_addr;
         ram_wdata = hold_data;
      end
      ram_ren   = req_rd && res_n;
      ram_raddr = req_rd ? sw_address : rd_addr;
   end

   // Response pulses, parked write, read capture and ECC event counters.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         sw_access_complete <= 1'b0;
         sw_invalid         <= 1'b0;
         sw_read_data       <= '0;
         hold_addr          <= '0;
         hold_data          <= '0;
         rd_addr            <= '0;
         wait_cnt           <= 1'b0;
         sec_cnt            <= '0;
         ded_cnt            <= '0;
      end else begin
         sw_access_complete <= req_bad || wr_now || hold_issue || rd_capture;
         sw_invalid         <= req_bad;
         if (req_rd) begin
            rd_addr  <= sw_address;
            wait_cnt <= WAIT_LOAD;
         end else if ((state == RD_WAIT) && !rd_capture) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (wr_defer) begin
            hold_addr <= sw_address;
            hold_data <= sw_write_data;
         end
         if (rd_capture) begin
            sw_read_data <= ram_rdata;
            if (ram_sec && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + 1'b1;
            if (ram_ded && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rf_ram_ctrl.sv
// Bench for rf_ram_ctrl: instance a (1-cycle RAM, 2-bit counters) runs a
// per-cycle vector table; instance b (2-cycle RAM) runs hand sequences for
// read latency and the hardware/software write collision.
module tb_rf_ram_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int CW = 2;

   logic clk;
   logic res_n;

   logic [AW-1:0] a_addr, b_addr;
   logic          a_rd, a_wr, b_rd, b_wr;
   logic [DW-1:0] a_wd, b_wd;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_cmp, a_inv, b_cmp, b_inv;
   logic          a_hw, b_hw;
   logic [AW-1:0] a_hwa, b_hwa;
   logic [DW-1:0] a_hwd, b_hwd;
   logic          a_wen, a_ren, b_wen, b_ren;
   logic [AW-1:0] a_waddr, a_raddr, b_waddr, b_raddr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic [DW-1:0] a_ram_rdata, b_ram_rdata, b_stage;
   logic          a_sec, a_ded, b_sec, b_ded;
   logic [CW-1:0] a_sec_cnt, a_ded_cnt, b_sec_cnt, b_ded_cnt;

   logic [DW-1:0] mem_a [16];
   logic [DW-1:0] mem_b [16];

   int n_vec = 0;
   int n_err = 0;

   rf_ram_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(0), .CNT_WIDTH(CW)) u_a (
      .clk(clk), .res_n(res_n),
      .sw_address(a_addr), .sw_read_en(a_rd), .sw_write_en(a_wr), .sw_write_data(a_wd),
      .sw_read_data(a_rdata), .sw_access_complete(a_cmp), .sw_invalid(a_inv),
      .hw_wen(a_hw), .hw_waddr(a_hwa), .hw_wdata(a_hwd),
      .ram_wen(a_wen), .ram_waddr(a_waddr), .ram_wdata(a_wdata),
      .ram_ren(a_ren), .ram_raddr(a_raddr),
      .ram_rdata(a_ram_rdata), .ram_sec(a_sec), .ram_ded(a_ded),
      .sec_cnt(a_sec_cnt), .ded_cnt(a_ded_cnt));

   rf_ram_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(1), .CNT_WIDTH(CW)) u_b (
      .clk(clk), .res_n(res_n),
      .sw_address(b_addr), .sw_read_en(b_rd), .sw_write_en(b_wr), .sw_write_data(b_wd),
      .sw_read_data(b_rdata), .sw_access_complete(b_cmp), .sw_invalid(b_inv),
      .hw_wen(b_hw), .hw_waddr(b_hwa), .hw_wdata(b_hwd),
      .ram_wen(b_wen), .ram_waddr(b_waddr), .ram_wdata(b_wdata),
      .ram_ren(b_ren), .ram_raddr(b_raddr),
      .ram_rdata(b_ram_rdata), .ram_sec(b_sec), .ram_ded(b_ded),
      .sec_cnt(b_sec_cnt), .ded_cnt(b_ded_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: read returns the pre-write content on a same-cycle collision.
   always @(posedge clk) begin
      if (a_wen) mem_a[a_waddr] <= a_wdata;
      if (a_ren) a_ram_rdata <= mem_a[a_raddr];
   end

   always @(posedge clk) begin
      if (b_wen) mem_b[b_waddr] <= b_wdata;
      if (b_ren) b_stage <= mem_b[b_raddr];
      b_ram_rdata <= b_stage;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rd, wr;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd;
      logic          hw;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      logic          sec, ded;
      logic          e_wen;
      logic [AW-1:0] e_wa;
      logic [DW-1:0] e_wd;
      logic          e_ren;
      logic [AW-1:0] e_ra;
      logic          e_cmp, e_inv;
      logic [DW-1:0] e_rd;
      logic [CW-1:0] e_sec, e_ded;
   } vec_t;

   function automatic vec_t mk(
      input logic rd, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
      input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
      input logic sec, input logic ded,
      input logic e_wen, input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd,
      input logic e_ren, input logic [AW-1:0] e_ra,
      input logic e_cmp, input logic e_inv, input logic [DW-1:0] e_rd,
      input logic [CW-1:0] e_sec, input logic [CW-1:0] e_ded);
      vec_t r;
      r.rd = rd;  r.wr = wr;  r.ad = ad;  r.wd = wd;
      r.hw = hw;  r.ha = ha;  r.hd = hd;  r.sec = sec;  r.ded = ded;
      r.e_wen = e_wen;  r.e_wa = e_wa;  r.e_wd = e_wd;
      r.e_ren = e_ren;  r.e_ra = e_ra;
      r.e_cmp = e_cmp;  r.e_inv = e_inv;  r.e_rd = e_rd;
      r.e_sec = e_sec;  r.e_ded = e_ded;
      return r;
   endfunction

   vec_t vt [22];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // stimulus   rd wr ad wd    hw ha hd    sc dd | wen wa wd    ren ra | cmp inv rdata sec ded
      vt[0]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0);
      vt[1]  = mk(0, 1, 3, 8'h5A, 0, 0, 8'h00, 0, 0,   1, 3, 8'h5A, 0, 0,   1, 0, 8'h00, 0, 0);
      vt[2]  = mk(1, 0, 3, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 1, 3,   0, 0, 8'h00, 0, 0);
      vt[3]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0,   1, 0, 8'h5A, 0, 0);
      vt[4]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0,   0, 0, 8'h5A, 0, 0);
      vt[5]  = mk(1, 1, 5, 8'h44, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0,   1, 1, 8'h5A, 0, 0);
      vt[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0,   0, 0, 8'h5A, 0, 0);
      vt[7]  = mk(0, 1, 4, 8'h33, 1, 1, 8'h77, 0, 0,   1, 1, 8'h77, 0, 0,   0, 0, 8'h5A, 0, 0);
      vt[8]  = mk(0, 1, 9, 8'hEE, 1, 2, 8'h22, 0, 0,   1, 2, 8'h22, 0, 0,   0, 0, 8'h5A, 0, 0);
      vt[9]  = mk(1, 0, 4, 8'h00, 0, 0, 8'h00, 0, 0,   1, 4, 8'h33, 0, 0,   1, 0, 8'h5A, 0, 0);
      vt[10] = mk(1, 0, 4, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 1, 4,   0, 0, 8'h5A, 0, 0);
      vt[11] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0,   1, 0, 8'h33, 1, 0);
      vt[12] = mk(1, 0, 1, 8'h00, 1, 1, 8'h99, 0, 0,   1, 1, 8'h99, 1, 1,   0, 0, 8'h33, 1, 0);
      vt[13] = mk(0, 1, 6, 8'h66, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0,   1, 0, 8'h77, 2, 0);
      vt[14] = mk(1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 1, 1,   0, 0, 8'h77, 2, 0);
      vt[15] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0,   1, 0, 8'h99, 3, 0);
      vt[16] = mk(1, 0, 3, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 1, 3,   0, 0, 8'h99, 3, 0);
      vt[17] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0,   1, 0, 8'h5A, 3, 0);
      vt[18] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1,   0, 0, 8'h00, 0, 0,   0, 0, 8'h5A, 3, 0);
      vt[19] = mk(0, 1, 3, 8'h01, 0, 0, 8'h00, 0, 0,   1, 3, 8'h01, 0, 0,   1, 0, 8'h5A, 3, 0);
      vt[20] = mk(1, 0, 2, 8'h00, 0, 0, 8'h00, 0, 0,   0, 0, 8'h00, 1, 2,   0, 0, 8'h5A, 3, 0);
      vt[21] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 8'h00, 0, 0,   1, 0, 8'h22, 3, 1);

      a_rd = 0; a_wr = 0; a_addr = 0; a_wd = 0; a_hw = 0; a_hwa = 0; a_hwd = 0;
      a_sec = 0; a_ded = 0;
      b_rd = 0; b_wr = 0; b_addr = 0; b_wd = 0; b_hw = 0; b_hwa = 0; b_hwd = 0;
      b_sec = 0; b_ded = 0;
      res_n = 1'b1;
      #1 res_n = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst a_cmp",   a_cmp, 0);
      chk("rst a_inv",   a_inv, 0);
      chk("rst a_rdata", a_rdata, 0);
      chk("rst a_sec",   a_sec_cnt, 0);
      chk("rst a_ded",   a_ded_cnt, 0);
      chk("rst a_wen",   a_wen, 0);
      chk("rst a_ren",   a_ren, 0);
      chk("rst b_cmp",   b_cmp, 0);
      chk("rst b_inv",   b_inv, 0);
      chk("rst b_rdata", b_rdata, 0);
      chk("rst b_sec",   b_sec_cnt, 0);
      chk("rst b_ded",   b_ded_cnt, 0);
      @(negedge clk);
      res_n = 1'b1;

      // table-driven cycles on instance a
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         a_rd = vt[i].rd;   a_wr = vt[i].wr;   a_addr = vt[i].ad;  a_wd = vt[i].wd;
         a_hw = vt[i].hw;   a_hwa = vt[i].ha;  a_hwd = vt[i].hd;
         a_sec = vt[i].sec; a_ded = vt[i].ded;
         #1;
         chk($sformatf("v%0d ram_wen", i), a_wen, vt[i].e_wen);
         if (vt[i].e_wen) begin
            chk($sformatf("v%0d ram_waddr", i), a_waddr, vt[i].e_wa);
            chk($sformatf("v%0d ram_wdata", i), a_wdata, vt[i].e_wd);
         end
         chk($sformatf("v%0d ram_ren", i), a_ren, vt[i].e_ren);
         if (vt[i].e_ren) chk($sformatf("v%0d ram_raddr", i), a_raddr, vt[i].e_ra);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d complete", i), a_cmp, vt[i].e_cmp);
         chk($sformatf("v%0d invalid", i), a_inv, vt[i].e_inv);
         chk($sformatf("v%0d read_data", i), a_rdata, vt[i].e_rd);
         chk($sformatf("v%0d sec_cnt", i), a_sec_cnt, vt[i].e_sec);
         chk($sformatf("v%0d ded_cnt", i), a_ded_cnt, vt[i].e_ded);
      end
      @(negedge clk);
      a_rd = 0; a_wr = 0; a_hw = 0; a_sec = 0; a_ded = 0;

      // instance b: plain write of 0x11 to addr 7
      @(negedge clk);
      b_wr = 1; b_addr = 7; b_wd = 8'h11;
      #1 chk("b wr7 ram_wen", b_wen, 1);
      @(posedge clk); #1 chk("b wr7 complete", b_cmp, 1);

      // instance b: sw write addr 2 0xAA parked behind 3 hw writes of 0xBB
      @(negedge clk);
      b_wr = 1; b_addr = 2; b_wd = 8'hAA; b_hw = 1; b_hwa = 2; b_hwd = 8'hBB;
      #1 chk("coll c1 wdata", b_wdata, 8'hBB);
      @(posedge clk); #1 chk("coll c1 complete", b_cmp, 0);
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         b_wr = 0;
         #1;
         chk($sformatf("coll c%0d wen", k), b_wen, 1);
         chk($sformatf("coll c%0d wdata", k), b_wdata, 8'hBB);
         @(posedge clk); #1 chk($sformatf("coll c%0d complete", k), b_cmp, 0);
      end
      @(negedge clk);
      b_hw = 0;
      #1;
      chk("coll c4 wen", b_wen, 1);
      chk("coll c4 waddr", b_waddr, 2);
      chk("coll c4 wdata", b_wdata, 8'hAA);
      @(posedge clk); #1 chk("coll c4 complete", b_cmp, 1);
      @(negedge clk);
      @(posedge clk); #1 chk("coll c5 complete", b_cmp, 0);

      // instance b: 2-cycle read of addr 7; completion two edges after the ren edge
      @(negedge clk);
      b_rd = 1; b_addr = 7;
      #1;
      chk("p1 rd7 ren", b_ren, 1);
      chk("p1 rd7 raddr", b_raddr, 7);
      @(posedge clk); #1 chk("p1 rd7 e0 complete", b_cmp, 0);
      @(negedge clk);
      b_rd = 0;
      #1 chk("p1 rd7 w1 ren", b_ren, 0);
      @(posedge clk); #1 chk("p1 rd7 e1 complete", b_cmp, 0);
      @(negedge clk);
      #1 chk("p1 rd7 w2 ren", b_ren, 0);
      @(posedge clk); #1;
      chk("p1 rd7 e2 complete", b_cmp, 1);
      chk("p1 rd7 data", b_rdata, 8'h11);
      @(negedge clk);
      @(posedge clk); #1 chk("p1 rd7 e3 complete", b_cmp, 0);

      // instance b: final content of addr 2 after the collision
      @(negedge clk);
      b_rd = 1; b_addr = 2;
      @(negedge clk);
      b_rd = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("p1 rd2 complete", b_cmp, 1);
      chk("p1 rd2 data", b_rdata, 8'hAA);

      // instance a: reset in the middle of RD_WAIT
      @(negedge clk);
      a_rd = 1; a_addr = 3;
      @(posedge clk); #1 chk("rstrd issue complete", a_cmp, 0);
      @(negedge clk);
      a_hw = 1; a_hwa = 8; a_hwd = 8'h88;
      res_n = 1'b0;
      #1;
      chk("rstrd cmp", a_cmp, 0);
      chk("rstrd rdata", a_rdata, 0);
      chk("rstrd sec", a_sec_cnt, 0);
      chk("rstrd ded", a_ded_cnt, 0);
      chk("rstrd ren", a_ren, 0);
      chk("rstrd hw wen", a_wen, 1);
      @(posedge clk); #1 chk("rstrd held complete", a_cmp, 0);
      @(negedge clk);
      res_n = 1'b1; a_rd = 0; a_hw = 0;
      @(posedge clk); #1 chk("rstrd after complete", a_cmp, 0);
      @(negedge clk);
      a_rd = 1; a_addr = 3;
      #1 chk("rstrd reread ren", a_ren, 1);
      @(negedge clk);
      a_rd = 0;
      @(posedge clk); #1;
      chk("rstrd reread complete", a_cmp, 1);
      chk("rstrd reread data", a_rdata, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_ram_ctrl.md
RF_RAM_CTRL -- requirements
Module: rf_ram_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 78, RAM data word width.
REQ-002 SHALL have parameter ADDRSIZE, default 9, RAM address width.
REQ-003 SHALL have parameter PIPELINED, default 0, matching the attached RAM read pipeline (0: 1-cycle read, 1: 2-cycle read).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the ECC event counters.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port res_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports sw_address  input  ADDRSIZE; sw_read_en  input  1; sw_write_en  input  1; sw_write_data  input  DATASIZE  (software request).
REQ-008 SHALL have ports sw_read_data  output  DATASIZE; sw_access_complete  output  1; sw_invalid  output  1  (software response).
REQ-009 SHALL have ports hw_wen  input  1; hw_waddr  input  ADDRSIZE; hw_wdata  input  DATASIZE  (hardware write, priority).
REQ-010 SHALL have ports ram_wen  output  1; ram_waddr  output  ADDRSIZE; ram_wdata  output  DATASIZE; ram_ren  output  1; ram_raddr  output  ADDRSIZE  (RAM drive).
REQ-011 SHALL have ports ram_rdata  input  DATASIZE; ram_sec  input  1; ram_ded  input  1  (RAM read return).
REQ-012 SHALL have ports sec_cnt  output  CNT_WIDTH; ded_cnt  output  CNT_WIDTH  (ECC event counts).

Function
REQ-013 SHALL implement FSM states IDLE, WR_HOLD, RD_WAIT; requests sampled only in IDLE, ignored elsewhere.
REQ-014 SHALL, in IDLE with sw_read_en and sw_write_en both high, pulse sw_invalid and sw_access_complete together for one cycle next edge, no RAM access, stay IDLE.
REQ-015 SHALL, in IDLE with sw_read_en only, drive ram_ren=1, ram_raddr=sw_address combinationally that cycle, register the address, go RD_WAIT.
REQ-016 SHALL stay in RD_WAIT for PIPELINED+1 cycles counted from the ram_ren cycle; on the final cycle capture ram_rdata into sw_read_data, pulse sw_access_complete, return IDLE.
REQ-017 SHALL hold ram_ren low during RD_WAIT (PIPELINED=1 RAM requires ren only in issue cycle).
REQ-018 SHALL, in IDLE with sw_write_en only and hw_wen low, drive ram_wen=1, ram_waddr=sw_address, ram_wdata=sw_write_data that cycle and pulse sw_access_complete next edge.
REQ-019 SHALL, when sw_write_en and hw_wen coincide, pass the hw write to the RAM, latch sw address/data, go WR_HOLD.
REQ-020 SHALL in WR_HOLD issue the latched sw write in the first cycle hw_wen is low, pulse sw_access_complete next edge, return IDLE.
REQ-021 SHALL forward hw_wen/hw_waddr/hw_wdata to the RAM write port whenever hw_wen=1, in every state.
REQ-022 SHALL not forward read-during-write data; same-address read and write in one cycle returns RAM's old content.
REQ-023 SHALL sample ram_sec/ram_ded only in the capture cycle of REQ-016; each high increments its counter by 1, saturating at all-ones.
REQ-024 SHALL hold sw_read_data between reads; writes do not change it.
REQ-025 SHALL keep sw_access_complete and sw_invalid as single-cycle registered pulses.

Reset
REQ-026 SHALL on res_n low, asynchronously: state IDLE, sw_read_data 0, sw_access_complete 0, sw_invalid 0, sec_cnt 0, ded_cnt 0, latched sw address/data 0.
REQ-027 SHALL abandon any RD_WAIT or WR_HOLD operation on reset without completion pulse; pending held write is discarded.
REQ-028 SHALL drive ram_wen/ram_ren low during reset except hw_wen pass-through of REQ-021.

Verification
REQ-029 SHALL cover: PIPELINED=0, write 0x5A to addr 3, read addr 3 -> ram_ren 1 cycle, sw_access_complete 1 cycle later, sw_read_data=0x5A.
REQ-030 SHALL cover: PIPELINED=1, read addr 7 holding 0x11 -> sw_access_complete exactly 2 cycles after ram_ren, data 0x11.
REQ-031 SHALL cover: sw write addr 2 data 0xAA with hw_wen high 3 cycles to addr 2 data 0xBB -> hw writes first, sw write issued cycle 4, final RAM[2]=0xAA.
REQ-032 SHALL cover: sw_read_en and sw_write_en together -> sw_invalid=1 and sw_access_complete=1 one cycle, no ram_wen/ram_ren.
REQ-033 SHALL cover: CNT_WIDTH=2, four reads with ram_sec=1 -> sec_cnt 1,2,3,3; ded_cnt 0.
REQ-034 SHALL cover: res_n low during RD_WAIT -> no sw_access_complete, outputs zero, next read completes normally.
